// File: rtl/comparator_pkg.sv
// Shared types for the sequential comparator: FSM state encoding and the
// 2-bit result code produced by the per-chunk magnitude compare.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;

endpackage

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit unsigned magnitude compare returning the
// comparator_pkg result code.
module chunk_cmp
  import comparator_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [1:0]       res
);

  always_comb begin
    res = RES_EQ;
    if (a > b) begin
      res = RES_GT;
    end else if (a < b) begin
      res = RES_LT;
    end
  end

endmodule

// File: rtl/comparator_seq.sv
// Sequential MSB-first magnitude comparator, CHUNK bits per cycle.
// Macro COMPARATOR_EARLY_EXIT_EN: stop at the first differing chunk; otherwise constant latency.
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_signed,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_GT,
  output logic             o_LT,
  output logic             o_EQ
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(NCHUNK - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k;
  logic             start_ok;
  logic             finish;
  logic [1:0]       cmp_res;
  logic [1:0]       final_res;
  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];

`ifndef COMPARATOR_EARLY_EXIT_EN
  logic       found_q;
  logic [1:0] res_q;
`endif

  for (genvar g = 0; g < NCHUNK; g++) begin : g_split
    assign a_chunk[g] = a_q[g*CHUNK +: CHUNK];
    assign b_chunk[g] = b_q[g*CHUNK +: CHUNK];
  end

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a   (a_chunk[k]),
    .b   (b_chunk[k]),
    .res (cmp_res)
  );

  assign o_busy = (state == COMPARE);
  assign o_done = (state == DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Without early exit, the first difference seen wins; later chunks only run out the clock.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    finish     = 1'b0;
    final_res  = cmp_res;
    case (state)
      IDLE: begin
        if (i_start) begin
          start_ok   = 1'b1;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
`ifdef COMPARATOR_EARLY_EXIT_EN
        if (cmp_res != RES_EQ || k == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
`else
        if (k == '0) begin
          finish     = 1'b1;
          final_res  = found_q ? res_q : cmp_res;
          state_next = DONE;
        end
`endif
      end
      DONE: begin
        if (i_start) begin
          start_ok   = 1'b1;
          state_next = COMPARE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q  <= '0;
      b_q  <= '0;
      k    <= '0;
      o_GT <= 1'b0;
      o_LT <= 1'b0;
      o_EQ <= 1'b0;
`ifndef COMPARATOR_EARLY_EXIT_EN
      found_q <= 1'b0;
      res_q   <= RES_EQ;
`endif
    end else if (start_ok) begin
      a_q  <= i_A ^ {i_signed, {(WIDTH-1){1'b0}}};
      b_q  <= i_B ^ {i_signed, {(WIDTH-1){1'b0}}};
      k    <= K_TOP;
      o_GT <= 1'b0;
      o_LT <= 1'b0;
      o_EQ <= 1'b0;
`ifndef COMPARATOR_EARLY_EXIT_EN
      found_q <= 1'b0;
      res_q   <= RES_EQ;
`endif
    end else if (state == COMPARE) begin
      if (finish) begin
        o_GT <= (final_res == RES_GT);
        o_LT <= (final_res == RES_LT);
        o_EQ <= (final_res == RES_EQ);
      end else begin
        k <= k - KW'(1);
      end
`ifndef COMPARATOR_EARLY_EXIT_EN
      if (!found_q && cmp_res != RES_EQ) begin
        found_q <= 1'b1;
        res_q   <= cmp_res;
      end
`endif
    end
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Scoreboard bench for comparator_seq (WIDTH=8, CHUNK=2); follows
// COMPARATOR_EARLY_EXIT_EN to pick the expected latency.
module tb_comparator_seq;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [2:0] flags;
    int         start;
    int         m;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_A      (a),
    .i_B      (b),
    .i_signed (sgn),
    .o_busy   (busy),
    .o_done   (done),
    .o_GT     (gt),
    .o_LT     (lt),
    .o_EQ     (eq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference result as {GT, LT, EQ} from plain integer comparison.
  function automatic logic [2:0] ref_flags(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic s);
    longint vx;
    longint vy;
    vx = s ? longint'($signed(x)) : longint'(x);
    vy = s ? longint'($signed(y)) : longint'(y);
    if (vx > vy) return 3'b100;
    if (vx < vy) return 3'b010;
    return 3'b001;
  endfunction

  // Number of compare cycles: chunks visited until the top differing one.
  function automatic int ref_cycles(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
`ifdef COMPARATOR_EARLY_EXIT_EN
    for (int j = NCHUNK - 1; j >= 0; j--) begin
      if (((x >> (j * CHUNK)) & 3) != ((y >> (j * CHUNK)) & 3)) return NCHUNK - j;
    end
`endif
    return NCHUNK;
  endfunction

  task automatic checkOutput(string name, longint actual, longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Waits until a start would be accepted, then issues one and records the expectation.
  task automatic applyStimulus(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic s);
    exp_t e;
    int   guard;
    guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("idle_wait_timeout", 1, 0);
    a     = x;
    b     = y;
    sgn   = s;
    start = 1'b1;
    e.flags = ref_flags(x, y, s);
    e.start = cyc + 1;
    e.m     = ref_cycles(x, y);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(int limit);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: every o_done pulse pops one expectation and checks result and timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("result_flags", {gt, lt, eq}, e.flags);
          checkOutput("done_latency", cyc - e.start, e.m);
          checkOutput("busy_cycles", busy_cnt, e.m);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sgn   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {busy, done, gt, lt, eq}, 5'b0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'hA5, 8'h5A, 1'b0);
    applyStimulus(8'hA5, 8'h5A, 1'b1);
    applyStimulus(8'h3C, 8'h3C, 1'b0);
    applyStimulus(8'h81, 8'h80, 1'b0);
    applyStimulus(8'h80, 8'h7F, 1'b1);
    applyStimulus(8'hFF, 8'h00, 1'b1);
    drain(100);

    // A start while busy must be ignored and the held result must survive.
    applyStimulus(8'h3C, 8'h3C, 1'b0);
    a     = 8'h00;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(100);
    repeat (3) @(negedge clk);
    checkOutput("result_hold", {gt, lt, eq}, 3'b001);

    // Reset two edges into a full-length compare aborts it.
    applyStimulus(8'h3C, 8'h3C, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_outputs", {busy, done, gt, lt, eq}, 5'b0);
    void'(sb.pop_back());
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("abort_idle", {busy, done, gt, lt, eq}, 5'b0);

    for (int i = 0; i < 200; i++) begin
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) y = x;
      if ($urandom_range(0, 3) == 0) y = {x[WIDTH-1:WIDTH-4], y[WIDTH-5:0]};
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      applyStimulus(x, y, 1'($urandom_range(0, 1)));
    end
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
